// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } ifu_state_e;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection for a retiring instruction: jump, taken branch or fall-through.
module next_pc_calc (
  input  logic [31:0] inst_pc,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        branch,
  input  logic [15:0] branch_offset,
  output logic [31:0] next_pc
);

  logic        [31:0] p4;
  logic signed [31:0] branch_disp;

  assign p4 = inst_pc + 32'd4;

  // Word offset sign-extended and scaled to bytes in one step.
  assign branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};

  always_comb begin
    next_pc = p4;
    if (jump) begin
      next_pc = {p4[31:28], jump_target, 2'b00};
    end else if (branch) begin
      next_pc = p4 + $unsigned(branch_disp);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, holds the word until the core retires it.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        branch,
  input  logic [15:0] branch_offset,
  output logic [31:0] retired_count
);

  ifu_state_e  state;
  logic [31:0] pc;
  logic [31:0] next_pc;

  next_pc_calc u_next_pc_calc (
    .inst_pc       (inst_pc),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch        (branch),
    .branch_offset (branch_offset),
    .next_pc       (next_pc)
  );

  // The PC register drives the address bus directly, so it is stable for the whole request.
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      imem_req      <= 1'b0;
      pc            <= RESET_PC;
      inst          <= NOP;
      inst_valid    <= 1'b0;
      inst_pc       <= RESET_PC;
      retired_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fetch_en) begin
            imem_req <= 1'b1;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (imem_ack) begin
            inst       <= imem_rdata;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            imem_req   <= 1'b0;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (inst_ready) begin
            inst_valid    <= 1'b0;
            pc            <= next_pc;
            retired_count <= retired_count + 32'd1;
            if (fetch_en) begin
              imem_req <= 1'b1;
              state    <= ST_REQ;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus a randomized run against an arithmetic PC model.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        jump;
  logic [25:0] jump_target;
  logic        branch;
  logic [15:0] branch_offset;
  logic [31:0] retired_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_count;

  inst_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst          (inst),
    .inst_valid    (inst_valid),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch        (branch),
    .branch_offset (branch_offset),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference next-PC from the architectural rules, using 64-bit arithmetic masked to 32 bits.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input bit j,
                                             input logic [25:0] jt, input bit b,
                                             input logic [15:0] off);
    longint p4;
    longint r;
    p4 = (longint'(pc) + 4) & 64'hFFFF_FFFF;
    if (j)      r = (p4 & 64'hF000_0000) + longint'(jt) * 4;
    else if (b) r = p4 + 4 * longint'($signed(off));
    else        r = p4;
    return 32'(r & 64'hFFFF_FFFF);
  endfunction

  task automatic do_reset();
    fetch_en = 1'b0;
    imem_ack = 1'b0;
    inst_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'h0;
    exp_count = 32'h0;
  endtask

  // Waits (bounded) for a request, optionally stalls, then acks with data. Returns at the negedge after the capture edge.
  task automatic serve_req(input int lat, input logic [31:0] data, output bit ok,
                           output logic [31:0] addr, output bit stable);
    ok = 1'b0;
    stable = 1'b1;
    addr = 32'hx;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (imem_req === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) return;
    addr = imem_addr;
    repeat (lat) begin
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== addr || inst_valid !== 1'b0) stable = 1'b0;
    end
    imem_ack = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
  endtask

  // Holds in HOLD for 'hold' cycles with junk on don't-care inputs, then retires with the given redirect.
  task automatic retire(input int hold, input bit j, input logic [25:0] jt, input bit b,
                        input logic [15:0] off, output bit stable);
    logic [31:0] i0, p0;
    i0 = inst;
    p0 = inst_pc;
    stable = 1'b1;
    repeat (hold) begin
      imem_ack = 1'($urandom);
      imem_rdata = $urandom;
      jump = 1'($urandom);
      branch = 1'($urandom);
      jump_target = 26'($urandom);
      branch_offset = 16'($urandom);
      @(negedge clk);
      if (inst !== i0 || inst_pc !== p0 || inst_valid !== 1'b1 || imem_req !== 1'b0) stable = 1'b0;
    end
    imem_ack = 1'b0;
    inst_ready = 1'b1;
    jump = j;
    jump_target = jt;
    branch = b;
    branch_offset = off;
    @(negedge clk);
    inst_ready = 1'b0;
    jump = 1'($urandom);
    branch = 1'($urandom);
    jump_target = 26'($urandom);
    branch_offset = 16'($urandom);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req=%b addr=%h valid=%b, expected 0/00000000/0", imem_req, imem_addr, inst_valid);
    end
    checks++;
    if (inst !== 32'h0 || inst_pc !== 32'h0 || retired_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: inst=%h pc=%h count=%h, expected all zero", inst, inst_pc, retired_count);
    end
  endtask

  task automatic test_start();
    bit ok, st;
    logic [31:0] a, d;
    do_reset();
    fetch_en = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL start_req: req=%b addr=%h, expected 1/00000000", imem_req, imem_addr);
    end
    d = $urandom;
    serve_req(0, d, ok, a, st);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== d) begin
      errors++;
      $display("FAIL start_capture: valid=%b pc=%h inst=%h, expected 1/00000000/%h", inst_valid, inst_pc, inst, d);
    end
    retire(0, 1'b0, 26'h0, 1'b0, 16'h0, st);
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4 || retired_count !== 32'h1) begin
      errors++;
      $display("FAIL start_retire: valid=%b req=%b addr=%h count=%h, expected 0/1/00000004/1",
               inst_valid, imem_req, imem_addr, retired_count);
    end
  endtask

  task automatic test_sequential();
    bit ok, st, st2;
    logic [31:0] a, d;
    do_reset();
    fetch_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = $urandom;
      serve_req(3, d, ok, a, st);
      checks++;
      if (!ok || a !== 32'(k * 4) || !st) begin
        errors++;
        $display("FAIL seq_req[%0d]: ok=%b addr=%h stable=%b, expected 1/%h/1", k, ok, a, st, 32'(k * 4));
      end
      checks++;
      if (inst !== d || inst_pc !== 32'(k * 4) || inst_valid !== 1'b1) begin
        errors++;
        $display("FAIL seq_inst[%0d]: inst=%h pc=%h valid=%b, expected %h/%h/1", k, inst, inst_pc, inst_valid, d, 32'(k * 4));
      end
      retire($urandom_range(0, 2), 1'b0, 26'h0, 1'b0, 16'h0, st2);
      checks++;
      if (!st2) begin
        errors++;
        $display("FAIL seq_hold[%0d]: instruction or pc changed during HOLD", k);
      end
    end
    checks++;
    if (retired_count !== 32'd4) begin
      errors++;
      $display("FAIL seq_count: got %0d, expected 4", retired_count);
    end
  endtask

  typedef struct {
    bit          j;
    logic [25:0] jt;
    bit          b;
    logic [15:0] off;
  } redir_t;

  task automatic test_redirects();
    bit ok, st;
    logic [31:0] a, d;
    redir_t r [4];
    logic [31:0] want [5];
    r[0] = '{1'b1, 26'h10, 1'b1, 16'h0123};
    r[1] = '{1'b0, 26'h0,  1'b1, 16'hFFFE};
    r[2] = '{1'b0, 26'h0,  1'b1, 16'hFFEF};
    r[3] = '{1'b0, 26'h0,  1'b0, 16'h0};
    want[0] = 32'h0000_0000;
    want[1] = 32'h0000_0040;
    want[2] = 32'h0000_003C;
    want[3] = 32'hFFFF_FFFC;
    want[4] = 32'h0000_0000;
    do_reset();
    fetch_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      d = $urandom;
      serve_req($urandom_range(0, 2), d, ok, a, st);
      checks++;
      if (!ok || a !== want[k] || inst_pc !== want[k]) begin
        errors++;
        $display("FAIL redirect[%0d]: ok=%b addr=%h inst_pc=%h, expected %h", k, ok, a, inst_pc, want[k]);
      end
      if (k < 4) retire($urandom_range(0, 1), r[k].j, r[k].jt, r[k].b, r[k].off, st);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] i0, p0, c0;
    bit st;
    i0 = inst;
    p0 = inst_pc;
    c0 = retired_count;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || inst !== i0 || inst_pc !== p0 || retired_count !== c0 || inst_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure[%0d]: req=%b inst=%h pc=%h count=%h valid=%b, expected 0/%h/%h/%h/1",
                 k, imem_req, inst, inst_pc, retired_count, inst_valid, i0, p0, c0);
      end
    end
    retire(0, 1'b0, 26'h0, 1'b0, 16'h0, st);
    checks++;
    if (retired_count !== c0 + 32'd1) begin
      errors++;
      $display("FAIL backpressure_retire: count=%h, expected %h", retired_count, c0 + 32'd1);
    end
  endtask

  task automatic test_reset_mid_req();
    bit ok, st;
    logic [31:0] a;
    do_reset();
    fetch_en = 1'b1;
    serve_req(0, $urandom, ok, a, st);
    retire(0, 1'b1, 26'h40, 1'b0, 16'h0, st);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL midreq_setup: req=%b addr=%h, expected 1/00000100", imem_req, imem_addr);
    end
    #2;
    rst = 1'b1;
    fetch_en = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreq_async: req=%b addr=%h valid=%b, expected 0/00000000/0", imem_req, imem_addr, inst_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0) begin
      errors++;
      $display("FAIL midreq_late_ack: req=%b valid=%b inst=%h, expected 0/0/00000000", imem_req, inst_valid, inst);
    end
    fetch_en = 1'b1;
    serve_req(1, $urandom, ok, a, st);
    checks++;
    if (!ok || a !== 32'h0) begin
      errors++;
      $display("FAIL midreq_restart: ok=%b addr=%h, expected 1/00000000", ok, a);
    end
    retire(0, 1'b0, 26'h0, 1'b0, 16'h0, st);
  endtask

  task automatic test_fetch_en_drop();
    bit ok, st;
    logic [31:0] a;
    fetch_en = 1'b0;
    serve_req(2, $urandom, ok, a, st);
    checks++;
    if (!ok || a !== 32'h4 || inst_valid !== 1'b1 || inst_pc !== 32'h4) begin
      errors++;
      $display("FAIL drop_complete: ok=%b addr=%h valid=%b pc=%h, expected 1/00000004/1/00000004", ok, a, inst_valid, inst_pc);
    end
    retire(1, 1'b0, 26'h0, 1'b0, 16'h0, st);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL drop_idle[%0d]: req=%b valid=%b, expected 0/0", k, imem_req, inst_valid);
      end
      @(negedge clk);
    end
    fetch_en = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL drop_resume: req=%b addr=%h, expected 1/00000008", imem_req, imem_addr);
    end
    serve_req(0, $urandom, ok, a, st);
    retire(0, 1'b0, 26'h0, 1'b0, 16'h0, st);
  endtask

  task automatic test_random();
    bit ok, st, j, b;
    logic [31:0] a, d;
    logic [25:0] jt;
    logic [15:0] off;
    do_reset();
    fetch_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      d = $urandom;
      serve_req($urandom_range(0, 3), d, ok, a, st);
      checks++;
      if (!ok || a !== exp_pc || !st || inst !== d || inst_pc !== exp_pc) begin
        errors++;
        $display("FAIL random_fetch[%0d]: ok=%b addr=%h stable=%b inst=%h pc=%h, expected addr/pc %h inst %h",
                 k, ok, a, st, inst, inst_pc, exp_pc, d);
      end
      j = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 2) == 0);
      jt = 26'($urandom);
      off = 16'($urandom);
      if ($urandom_range(0, 3) == 0) fetch_en = 1'b0;
      retire($urandom_range(0, 3), j, jt, b, off, st);
      exp_pc = model_next(exp_pc, j, jt, b, off);
      exp_count = exp_count + 32'd1;
      checks++;
      if (!st || retired_count !== exp_count || inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL random_retire[%0d]: stable=%b count=%0d valid=%b, expected 1/%0d/0",
                 k, st, retired_count, inst_valid, exp_count);
      end
      if (fetch_en == 1'b0) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
          errors++;
          $display("FAIL random_idle[%0d]: req=%b, expected 0", k, imem_req);
        end
        fetch_en = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    fetch_en = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    inst_ready = 1'b0;
    jump = 1'b0;
    jump_target = 26'h0;
    branch = 1'b0;
    branch_offset = 16'h0;
    exp_pc = 32'h0;
    exp_count = 32'h0;
    test_reset();
    test_start();
    test_sequential();
    test_redirects();
    test_backpressure();
    test_reset_mid_req();
    test_fetch_en_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
